// File: rtl/zigma_trace_buffer.sv
// zigma_trace_buffer: armed/triggered trace capture FIFO for pc, ALU result
// and register write data, with optional circular (WRAP) capture.
// Optional feature macro: ZIGMA_TRACE_TIMESTAMP_EN adds a 32-bit cycle
// timestamp per entry, returned on rd_ts.
//
// Handshake: a pop is accepted on any rising edge where rd_en=1 and empty=0;
// the popped entry is on rd_* with rd_valid=1 during the following cycle.
// rd_en while empty is ignored and rd_* keep their previous value.
module zigma_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int WRAP  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [XLEN-1:0]          trig_pc,
  input  logic                     cap_valid,
  input  logic [XLEN-1:0]          cap_pc,
  input  logic [XLEN-1:0]          cap_alu,
  input  logic [XLEN-1:0]          cap_wdata,
  input  logic                     rd_en,
  output logic [XLEN-1:0]          rd_pc,
  output logic [XLEN-1:0]          rd_alu,
  output logic [XLEN-1:0]          rd_wdata,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
`ifdef ZIGMA_TRACE_TIMESTAMP_EN
  output logic [31:0]              rd_ts,
`endif
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q;
  logic            clear, do_wr, do_rd, drop, overwrite;

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [XLEN-1:0] mem_alu   [DEPTH];
  logic [XLEN-1:0] mem_wdata [DEPTH];

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign state    = state_q;

  // Next-state and per-cycle actions; arm in any state restarts the session.
  always_comb begin
    state_d   = state_q;
    clear     = 1'b0;
    do_wr     = 1'b0;
    do_rd     = rd_en && !empty;
    drop      = 1'b0;
    overwrite = 1'b0;
    count_d   = count_q;
    if (arm) begin
      clear   = 1'b1;
      do_rd   = 1'b0;
      state_d = trig_en ? ARMED : CAPTURE;
    end else begin
      case (state_q)
        ARMED: begin
          if (cap_valid && (cap_pc == trig_pc)) begin
            do_wr   = 1'b1;
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (cap_valid) begin
            if (!full || (WRAP != 0) || do_rd) do_wr = 1'b1;
            else                               drop  = 1'b1;
          end
        end
        DONE: begin
          if (cap_valid) drop = 1'b1;
        end
        default: ;
      endcase
    end
    // A write into a full buffer with no pop in the same cycle evicts the oldest.
    overwrite = do_wr && full && !do_rd;
    if (clear)                                count_d = '0;
    else if (do_wr && !do_rd && !overwrite)   count_d = count_q + CW'(1);
    else if (do_rd && !do_wr)                 count_d = count_q - CW'(1);
    if (!clear && (state_q == CAPTURE) && (WRAP == 0) && (count_d == DEPTH_C))
      state_d = DONE;
  end

  // State, pointers, count, sticky overflow and registered read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rd_valid <= 1'b0;
      rd_pc    <= '0;
      rd_alu   <= '0;
      rd_wdata <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (clear) begin
        wptr     <= '0;
        rptr     <= '0;
        ovf_q    <= 1'b0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= do_rd;
        if (do_wr)              wptr  <= wptr + AW'(1);
        if (do_rd || overwrite) rptr  <= rptr + AW'(1);
        if (drop || overwrite)  ovf_q <= 1'b1;
        if (do_rd) begin
          rd_pc    <= mem_pc[rptr];
          rd_alu   <= mem_alu[rptr];
          rd_wdata <= mem_wdata[rptr];
        end
      end
    end
  end

  // Entry storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_pc[wptr]    <= cap_pc;
      mem_alu[wptr]   <= cap_alu;
      mem_wdata[wptr] <= cap_wdata;
    end
  end

`ifdef ZIGMA_TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] mem_ts [DEPTH];

  // Free-running cycle counter and the registered timestamp read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q  <= '0;
      rd_ts <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
      if (do_rd && !clear) rd_ts <= mem_ts[rptr];
    end
  end

  // Timestamp storage alongside each entry.
  always_ff @(posedge clk) begin
    if (do_wr) mem_ts[wptr] <= ts_q;
  end
`endif

endmodule

// File: tb/tb_zigma_trace_buffer.sv
// Testbench for zigma_trace_buffer: three instances (DEPTH 16 stop-when-full,
// DEPTH 4 stop-when-full, DEPTH 4 circular) share one stimulus stream and are
// each compared against a queue-based reference model every cycle.
module tb_zigma_trace_buffer;

  typedef logic [95:0] ent_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic        arm = 1'b0, trig_en = 1'b0, cap_valid = 1'b0, rd_en = 1'b0;
  logic [31:0] trig_pc = '0, cap_pc = '0, cap_alu = '0, cap_wdata = '0;

  // ---------------- DUT outputs ----------------
  logic [2:0][31:0] rd_pc_o, rd_alu_o, rd_wd_o;
  logic [2:0]       rv_o, full_o, empty_o, ovf_o;
  logic [2:0][1:0]  st_o;
  logic [4:0]       cnt0;
  logic [2:0]       cnt1, cnt2;

  zigma_trace_buffer #(.XLEN(32), .DEPTH(16), .WRAP(0)) u_d16 (
    .clk(clk), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_alu(cap_alu), .cap_wdata(cap_wdata),
    .rd_en(rd_en), .rd_pc(rd_pc_o[0]), .rd_alu(rd_alu_o[0]), .rd_wdata(rd_wd_o[0]),
    .rd_valid(rv_o[0]), .count(cnt0), .full(full_o[0]), .empty(empty_o[0]),
    .overflow(ovf_o[0]), .state(st_o[0]));

  zigma_trace_buffer #(.XLEN(32), .DEPTH(4), .WRAP(0)) u_stop (
    .clk(clk), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_alu(cap_alu), .cap_wdata(cap_wdata),
    .rd_en(rd_en), .rd_pc(rd_pc_o[1]), .rd_alu(rd_alu_o[1]), .rd_wdata(rd_wd_o[1]),
    .rd_valid(rv_o[1]), .count(cnt1), .full(full_o[1]), .empty(empty_o[1]),
    .overflow(ovf_o[1]), .state(st_o[1]));

  zigma_trace_buffer #(.XLEN(32), .DEPTH(4), .WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_alu(cap_alu), .cap_wdata(cap_wdata),
    .rd_en(rd_en), .rd_pc(rd_pc_o[2]), .rd_alu(rd_alu_o[2]), .rd_wdata(rd_wd_o[2]),
    .rd_valid(rv_o[2]), .count(cnt2), .full(full_o[2]), .empty(empty_o[2]),
    .overflow(ovf_o[2]), .state(st_o[2]));

  // ---------------- reference model ----------------
  int   dep  [3] = '{16, 4, 4};
  bit   wrp  [3] = '{0, 0, 1};
  int   m_st [3];
  bit   m_ovf[3];
  bit   m_rv [3];
  ent_t m_last[3];
  ent_t mq0[$], mq1[$], mq2[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int msize(input int k);
    if (k == 0) return mq0.size();
    if (k == 1) return mq1.size();
    return mq2.size();
  endfunction

  task automatic model_reset();
    mq0.delete(); mq1.delete(); mq2.delete();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_ovf[k] = 0; m_rv[k] = 0; m_last[k] = '0;
    end
  endtask

  // One clock edge of behaviour for buffer k, from the current inputs.
  task automatic model_step(input int k);
    ent_t q[$];
    ent_t e;
    int   st;
    bit   ovf;
    if (k == 0) q = mq0; else if (k == 1) q = mq1; else q = mq2;
    st  = m_st[k];
    ovf = m_ovf[k];
    e   = {cap_pc, cap_alu, cap_wdata};
    m_rv[k] = 0;
    if (arm) begin
      q.delete();
      ovf = 0;
      st  = trig_en ? 1 : 2;
    end else begin
      if (rd_en && q.size() > 0) begin
        m_last[k] = q.pop_front();
        m_rv[k]   = 1;
      end
      if (cap_valid) begin
        if (st == 1) begin
          if (cap_pc == trig_pc) begin
            q.push_back(e);
            st = 2;
          end
        end else if (st == 2) begin
          if (q.size() < dep[k]) q.push_back(e);
          else begin
            ovf = 1;
            if (wrp[k]) begin
              void'(q.pop_front());
              q.push_back(e);
            end
          end
        end else if (st == 3) begin
          ovf = 1;
        end
      end
      if (st == 2 && !wrp[k] && q.size() == dep[k]) st = 3;
    end
    if (k == 0) mq0 = q; else if (k == 1) mq1 = q; else mq2 = q;
    m_st[k]  = st;
    m_ovf[k] = ovf;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [4:0] c;
    for (int k = 0; k < 3; k++) begin
      c = (k == 0) ? cnt0 : ((k == 1) ? {2'b00, cnt1} : {2'b00, cnt2});
      chk($sformatf("state[%0d]", k), 128'(st_o[k]), 128'(m_st[k]));
      chk($sformatf("count[%0d]", k), 128'(c), 128'(msize(k)));
      chk($sformatf("full[%0d]", k), 128'(full_o[k]), 128'(msize(k) == dep[k]));
      chk($sformatf("empty[%0d]", k), 128'(empty_o[k]), 128'(msize(k) == 0));
      chk($sformatf("overflow[%0d]", k), 128'(ovf_o[k]), 128'(m_ovf[k]));
      chk($sformatf("rd_valid[%0d]", k), 128'(rv_o[k]), 128'(m_rv[k]));
      chk($sformatf("rd_data[%0d]", k), 128'({rd_pc_o[k], rd_alu_o[k], rd_wd_o[k]}),
          128'(m_last[k]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    for (int k = 0; k < 3; k++) model_step(k);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    arm = 1'b0; cap_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_arm(input logic te, input logic [31:0] tpc);
    quiet();
    arm = 1'b1; trig_en = te; trig_pc = tpc;
    cycle();
    arm = 1'b0;
  endtask

  task automatic set_sample(input logic [31:0] pc);
    cap_valid = 1'b1; cap_pc = pc; cap_alu = $urandom; cap_wdata = $urandom;
  endtask

  task automatic sample(input logic [31:0] pc);
    quiet();
    set_sample(pc);
    cycle();
    cap_valid = 1'b0;
  endtask

  task automatic pop();
    quiet();
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Immediate capture, in-order readback with one-cycle latency.
    do_arm(1'b0, '0);
    for (int i = 0; i < 5; i++) sample(32'(i * 4));
    chk("req031_count", 128'(cnt0), 128'(5));
    for (int i = 0; i < 5; i++) begin
      pop();
      chk("req031_rd_valid", 128'(rv_o[0]), 128'(1));
      chk("req031_rd_pc", 128'(rd_pc_o[0]), 128'(i * 4));
    end
    quiet();
    cycle();
    chk("req031_valid_drop", 128'(rv_o[0]), 128'(0));

    // Triggered capture: nothing stored until pc matches.
    do_arm(1'b1, 32'h8);
    sample(32'h0);
    chk("req032_armed0", 128'(st_o[0]), 128'(1));
    sample(32'h4);
    chk("req032_armed4", 128'(st_o[0]), 128'(1));
    sample(32'h8);
    chk("req032_capture", 128'(st_o[0]), 128'(2));
    sample(32'hC);
    chk("req032_count", 128'(cnt0), 128'(2));
    pop();
    chk("req032_first", 128'(rd_pc_o[0]), 128'(8));
    pop();

    // Six samples into the DEPTH 4 buffers: stop vs. wrap.
    do_arm(1'b0, '0);
    for (int i = 1; i <= 6; i++) sample(32'(i));
    chk("req033_state", 128'(st_o[1]), 128'(3));
    chk("req033_full", 128'(full_o[1]), 128'(1));
    chk("req033_ovf", 128'(ovf_o[1]), 128'(1));
    chk("req034_count", 128'(cnt2), 128'(4));
    chk("req034_ovf", 128'(ovf_o[2]), 128'(1));
    for (int i = 0; i < 4; i++) begin
      pop();
      chk("req033_rd_pc", 128'(rd_pc_o[1]), 128'(i + 1));
      chk("req034_rd_pc", 128'(rd_pc_o[2]), 128'(i + 3));
    end
    chk("req024_done_drained", 128'(st_o[1]), 128'(3));

    // Simultaneous read and write at count 2, then read while empty.
    do_arm(1'b0, '0);
    sample(32'h100);
    sample(32'h104);
    quiet();
    set_sample(32'h108);
    rd_en = 1'b1;
    cycle();
    quiet();
    chk("req035_count", 128'(cnt0), 128'(2));
    chk("req035_rd_pc", 128'(rd_pc_o[0]), 128'(32'h100));
    pop();
    pop();
    pop();
    chk("req035_empty_rd", 128'(rv_o[0]), 128'(0));

    // Simultaneous read and write while full (wrap keeps count, returns oldest).
    do_arm(1'b0, '0);
    for (int i = 0; i < 4; i++) sample(32'h200 + 32'(i));
    quiet();
    set_sample(32'h300);
    rd_en = 1'b1;
    cycle();
    quiet();
    chk("req023_wrap_count", 128'(cnt2), 128'(4));
    chk("req023_wrap_rd_pc", 128'(rd_pc_o[2]), 128'(32'h200));
    for (int i = 0; i < 4; i++) pop();

    // Asynchronous reset during capture at count 3.
    do_arm(1'b0, '0);
    for (int i = 0; i < 3; i++) sample(32'h40 + 32'(i));
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("req036_state", 128'(st_o[0]), 128'(0));
    chk("req036_count", 128'(cnt0), 128'(0));
    chk("req036_empty", 128'(empty_o[0]), 128'(1));
    chk("req036_ovf", 128'(ovf_o[1]), 128'(0));
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    // First edge after reset: only arm is looked at.
    quiet();
    set_sample(32'h0);
    rd_en = 1'b1;
    cycle();
    quiet();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      arm       = ($urandom_range(0, 24) == 0);
      trig_en   = 1'($urandom_range(0, 1));
      trig_pc   = 32'($urandom_range(0, 7) * 4);
      cap_valid = ($urandom_range(0, 2) != 0);
      cap_pc    = 32'($urandom_range(0, 7) * 4);
      cap_alu   = $urandom;
      cap_wdata = $urandom;
      rd_en     = ($urandom_range(0, 4) < 2);
      cycle();
    end
    quiet();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zigma_trace_buffer.md
ZIGMA_TRACE_BUFFER -- requirements
Module: zigma_trace_buffer

Interface
REQ-001 Parameter XLEN, default 32, width of each captured field.
REQ-002 Parameter DEPTH, default 16, entries; power of two, >=2.
REQ-003 Parameter WRAP, default 0; 1 = circular capture overwriting oldest, 0 = stop when full.
REQ-004 Port clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port arm  in  1  one-cycle pulse; starts a capture session.
REQ-007 Port trig_en  in  1  1 = wait for trig_pc match before capturing; 0 = capture immediately on arm.
REQ-008 Port trig_pc  in  XLEN  trigger program counter value.
REQ-009 Port cap_valid  in  1  sample of the current cycle is valid.
REQ-010 Port cap_pc / cap_alu / cap_wdata  in  XLEN each  sampled pc_number, ALU result and register write data.
REQ-011 Port rd_en  in  1  pop the oldest entry.
REQ-012 Port rd_pc / rd_alu / rd_wdata  out  XLEN each  oldest entry; registered.
REQ-013 Port rd_valid  out  1  rd_* holds popped data this cycle.
REQ-014 Port count  out  $clog2(DEPTH)+1  number of stored entries.
REQ-015 Port full / empty / overflow  out  1 each  status flags; overflow is sticky.
REQ-016 Port state  out  2  FSM state: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.

Function
REQ-017 IDLE: arm -> ARMED if trig_en=1, else -> CAPTURE; arm in any other state restarts the session: clears storage, count and overflow, then moves to ARMED or CAPTURE.
REQ-018 ARMED: cap_valid=1 and cap_pc==trig_pc -> CAPTURE, and the trigger sample itself is stored in the same edge.
REQ-019 CAPTURE: each cycle with cap_valid=1 writes {cap_pc,cap_alu,cap_wdata} at the write pointer; write pointer increments modulo DEPTH.
REQ-020 CAPTURE, WRAP=0: when count reaches DEPTH -> DONE; further cap_valid samples are dropped and set overflow.
REQ-021 CAPTURE, WRAP=1: write when full overwrites the oldest entry, advances the read pointer, holds count=DEPTH, sets overflow; the FSM stays in CAPTURE until the next arm.
REQ-022 rd_en with empty=0: data appears on rd_* and rd_valid=1 on the next cycle (1-cycle latency), read pointer increments modulo DEPTH, count decrements; rd_en with empty=1 is ignored and rd_valid=0.
REQ-023 Simultaneous write and read in the same cycle: both take effect, count unchanged; when full and WRAP=1, the read returns the oldest entry and the write does not advance the read pointer a second time.
REQ-024 Reads are permitted in every state; in DONE, draining the buffer keeps state=DONE.
REQ-025 full = (count==DEPTH); empty = (count==0); both are derived from registered count.
REQ-026 rd_* hold their last value when rd_valid=0.

Reset
REQ-027 While reset=1: state=IDLE, pointers=0, count=0, empty=1, full=0, overflow=0, rd_valid=0, rd_*=0; storage contents are don't-care.
REQ-028 Reset asserted mid-capture aborts immediately; the first edge after deassertion samples no input other than arm.

Configuration
REQ-029 Macro ZIGMA_TRACE_TIMESTAMP_EN defined: adds output rd_ts (32 bits) and a free-running 32-bit cycle counter, cleared by reset and wrapping at 2^32; each entry stores the counter value at its write edge.
REQ-030 Macro ZIGMA_TRACE_TIMESTAMP_EN undefined: no rd_ts port, no counter, no timestamp storage; all other behaviour is identical.

Verification
REQ-031 trig_en=0, arm, 5 valid samples pc=0,4,8,12,16 -> count=5; 5 reads return pc 0..16 in order, each with rd_valid one cycle after rd_en.
REQ-032 trig_en=1, trig_pc=0x8, samples pc=0,4,8,12 -> state 1 until pc=8; only 8 and 12 are stored (count=2).
REQ-033 WRAP=0, DEPTH=4, 6 samples -> state=DONE, full=1, overflow=1; reads return the first 4 samples.
REQ-034 WRAP=1, DEPTH=4, samples 1..6 -> count=4, overflow=1; reads return 3,4,5,6.
REQ-035 Simultaneous rd_en and cap_valid at count=2 -> count stays 2, correct oldest entry is returned; rd_en when empty -> rd_valid=0.
REQ-036 reset pulse during CAPTURE at count=3 -> state=0, count=0, empty=1, overflow=0 within the same cycle.
